// File: rtl/sat_link_pkg.sv
// Shared types and default geometry for the satellite daisy-chain master.
package sat_link_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_SAT = 2;
  localparam int unsigned DEF_CLK_DIV = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_SETUP,
    ST_LOAD_EN,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_TAIL,
    ST_DISABLE
  } state_t;

endpackage

// File: rtl/sat_link_tick.sv
// Phase timer: o_tc is high on the last of every DIV cycles; i_restart holds the count at zero.
// Held in restart while the master idles, so each non-idle state sees exactly DIV cycles.
module sat_link_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tc
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tc = (r_cnt == CW'(DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sat_link_master.sv
// Daisy-chain master: parallel-loads the satellites, then shifts WIDTH*NUM_SAT bits out and in.
// start-to-done is 2*CLK_DIV*(N+2) cycles; start is ignored while busy.
module sat_link_master
  import sat_link_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NUM_SAT = DEF_NUM_SAT,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic                     masterClk,
  input  logic                     nReset,
  input  logic                     start,
  input  logic [WIDTH*NUM_SAT-1:0] txData,
  output logic [WIDTH*NUM_SAT-1:0] rxData,
  output logic                     busy,
  output logic                     done,
  output logic                     shiftClk,
  output logic                     enableShift,
  output logic                     load,
  output logic                     serialOut,
  input  logic                     serialIn
);

  localparam int unsigned N  = WIDTH * NUM_SAT;
  localparam int unsigned BW = $clog2(N + 1);

  state_t         r_state;
  logic [N-1:0]   r_tx;
  logic [N-1:0]   r_rx;
  logic [N-1:0]   r_rxdata;
  logic [BW-1:0]  r_bit;
  logic           r_busy;
  logic           r_done;
  logic           r_sclk;
  logic           r_en;
  logic           r_load;
  logic           r_sout;
  logic           w_tc;
  logic           w_restart;
  logic [N-1:0]   w_tx_shl;

  assign w_restart = (r_state == ST_IDLE);
  assign w_tx_shl  = r_tx << 1;

  sat_link_tick #(
    .DIV (CLK_DIV)
  ) u_tick (
    .i_clk     (masterClk),
    .i_rst_n   (nReset),
    .i_restart (w_restart),
    .o_tc      (w_tc)
  );

  // Every chain output is a flop, set on the transition into the state that owns it.
  always_ff @(posedge masterClk or negedge nReset) begin
    if (!nReset) begin
      r_state  <= ST_IDLE;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rxdata <= '0;
      r_bit    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_en     <= 1'b0;
      r_load   <= 1'b0;
      r_sout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_tx    <= txData;
            r_bit   <= '0;
            r_busy  <= 1'b1;
            r_load  <= 1'b1;
            r_state <= ST_LOAD_SETUP;
          end
        end
        ST_LOAD_SETUP: begin
          if (w_tc) begin
            r_en    <= 1'b1;
            r_state <= ST_LOAD_EN;
          end
        end
        ST_LOAD_EN: begin
          if (w_tc) begin
            r_load  <= 1'b0;
            r_sout  <= r_tx[N-1];
            r_state <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          // serialIn is taken before the satellites see the rising shiftClk.
          if (w_tc) begin
            r_rx    <= {r_rx[N-2:0], serialIn};
            r_sclk  <= 1'b1;
            r_state <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (w_tc) begin
            r_sclk <= 1'b0;
            r_tx   <= w_tx_shl;
            r_bit  <= r_bit + BW'(1);
            if (r_bit == BW'(N - 1)) begin
              r_sout  <= 1'b0;
              r_state <= ST_TAIL;
            end else begin
              r_sout  <= w_tx_shl[N-1];
              r_state <= ST_SHIFT_LO;
            end
          end
        end
        ST_TAIL: begin
          if (w_tc) begin
            r_en    <= 1'b0;
            r_state <= ST_DISABLE;
          end
        end
        ST_DISABLE: begin
          if (w_tc) begin
            r_rxdata <= r_rx;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rxData      = r_rxdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign shiftClk    = r_sclk;
  assign enableShift = r_en;
  assign load        = r_load;
  assign serialOut   = r_sout;

endmodule

// File: tb/tb_sat_link_master.sv
// Bench for sat_link_master: default 2-satellite chain plus a 1-satellite, CLK_DIV=2 instance.
module tb_sat_link_master;

  localparam int D1 = 4;
  localparam int N1 = 16;
  localparam int T1 = 2 * D1 * (N1 + 2);
  localparam int D2 = 2;
  localparam int N2 = 8;
  localparam int T2 = 2 * D2 * (N2 + 2);

  logic        clk = 1'b0;
  logic        nReset = 1'b1;
  logic        start, start2;
  logic [15:0] txData, rxData;
  logic [7:0]  txData2, rxData2;
  logic        busy, done, shiftClk, enableShift, load, serialOut, serialIn;
  logic        busy2, done2, shiftClk2, enableShift2, load2, serialOut2, serialIn2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sat_link_master u_dut (
    .masterClk   (clk),
    .nReset      (nReset),
    .start       (start),
    .txData      (txData),
    .rxData      (rxData),
    .busy        (busy),
    .done        (done),
    .shiftClk    (shiftClk),
    .enableShift (enableShift),
    .load        (load),
    .serialOut   (serialOut),
    .serialIn    (serialIn)
  );

  sat_link_master #(.WIDTH(8), .NUM_SAT(1), .CLK_DIV(2)) u_dut2 (
    .masterClk   (clk),
    .nReset      (nReset),
    .start       (start2),
    .txData      (txData2),
    .rxData      (rxData2),
    .busy        (busy2),
    .done        (done2),
    .shiftClk    (shiftClk2),
    .enableShift (enableShift2),
    .load        (load2),
    .serialOut   (serialOut2),
    .serialIn    (serialIn2)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Expected {load, enableShift, shiftClk, serialOut} at cycle t of a transaction.
  function automatic logic [3:0] exp_chain(input int t, input int d, input int n, input logic [15:0] tx);
    int p;
    logic [3:0] r;
    p = t / d;
    r = 4'b0;
    r[3] = (p < 2);
    r[2] = (p >= 1) && (p <= 2 * n + 2);
    if (p >= 2 && p < 2 * n + 2) begin
      r[1] = ((p - 2) % 2 == 1);
      r[0] = tx[n - 1 - (p - 2) / 2];
    end
    return r;
  endfunction

  // Satellite models for the default chain, clocked off masterClk edges of the chain signals.
  logic       loop_mode;
  logic [7:0] sat_ld0, sat_ld1, sat0, sat1;
  logic       en_q, sclk_q;

  always @(posedge clk) begin
    if (enableShift && !en_q && load) begin
      sat0 <= sat_ld0;
      sat1 <= sat_ld1;
    end else if (shiftClk && !sclk_q) begin
      sat0 <= {sat0[6:0], serialOut};
      sat1 <= {sat1[6:0], sat0[7]};
    end
    en_q   <= enableShift;
    sclk_q <= shiftClk;
  end

  assign serialIn  = loop_mode ? serialOut : sat1[7];
  assign serialIn2 = serialOut2;

  int sclk_rises = 0;
  int done_cnt   = 0;
  always @(posedge shiftClk) sclk_rises <= sclk_rises + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // Transaction-level model, default instance.
  logic        m_act, m_done;
  int          m_t;
  logic [15:0] m_tx, m_rx;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_act <= 1'b0; m_done <= 1'b0; m_t <= 0; m_tx <= '0; m_rx <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        m_t <= m_t + 1;
        if (m_t == T1 - 1) begin
          m_act  <= 1'b0;
          m_done <= 1'b1;
          m_rx   <= loop_mode ? m_tx : {sat_ld1, sat_ld0};
        end
      end else if (start) begin
        m_act <= 1'b1; m_t <= 0; m_tx <= txData;
      end
    end
  end

  // Transaction-level model, loopback 1-satellite instance.
  logic       m2_act, m2_done;
  int         m2_t;
  logic [7:0] m2_tx, m2_rx;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m2_act <= 1'b0; m2_done <= 1'b0; m2_t <= 0; m2_tx <= '0; m2_rx <= '0;
    end else begin
      m2_done <= 1'b0;
      if (m2_act) begin
        m2_t <= m2_t + 1;
        if (m2_t == T2 - 1) begin
          m2_act <= 1'b0; m2_done <= 1'b1; m2_rx <= m2_tx;
        end
      end else if (start2) begin
        m2_act <= 1'b1; m2_t <= 0; m2_tx <= txData2;
      end
    end
  end

  logic en2_q;
  always @(negedge clk) begin
    logic [3:0] e1, e2;
    e1 = m_act ? exp_chain(m_t, D1, N1, m_tx) : 4'b0;
    e2 = m2_act ? exp_chain(m2_t, D2, N2, {8'h00, m2_tx}) : 4'b0;
    chk("dut1_cycle", {busy, done, load, enableShift, shiftClk, serialOut, rxData},
        {m_act, m_done, e1, m_rx});
    chk("dut2_cycle", {busy2, done2, load2, enableShift2, shiftClk2, serialOut2, rxData2},
        {m2_act, m2_done, e2, m2_rx});
    if (enableShift2 && !en2_q) chk("dut2_en_rise_load", load2, 1);
    en2_q <= enableShift2;
  end

  task automatic txn(input logic [15:0] tx, input int pulse_at, input int chg_at, output int lat);
    txData = tx;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      start = (lat == pulse_at);
      if (lat == chg_at) txData = ~tx;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time budget");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] tx2v [3];

  initial begin
    int lat, r0, d0;
    start = 0; start2 = 0; txData = '0; txData2 = '0;
    loop_mode = 0; sat_ld0 = 8'h3C; sat_ld1 = 8'hC3;
    tx2v[0] = 8'hA7; tx2v[1] = 8'h3B; tx2v[2] = 8'hD4;
    #2 nReset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, done, shiftClk, enableShift, load, serialOut}, 0);
    chk("reset_rxdata", rxData, 0);
    nReset = 1'b1;
    repeat (2) @(negedge clk);

    // Two satellites preloaded 3C/C3, send A55A.
    txn(16'hA55A, -1, -1, lat);
    chk("sat_latency", lat, 144);
    chk("sat_rxdata", rxData, 16'hC33C);
    chk("sat1_parallel", sat1, 8'hA5);
    chk("sat0_parallel", sat0, 8'h5A);
    repeat (3) @(negedge clk);

    // Loopback.
    loop_mode = 1;
    r0 = sclk_rises;
    txn(16'h1234, -1, -1, lat);
    chk("loop_rxdata", rxData, 16'h1234);
    chk("loop_sclk_rises", sclk_rises - r0, 16);
    chk("loop_latency", lat, 144);
    repeat (3) @(negedge clk);

    // Start pulse mid-flight ignored; txData changed mid-flight has no effect.
    d0 = done_cnt;
    txn(16'h5A5A, 10, 20, lat);
    repeat (20) @(negedge clk);
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_latency", lat, 144);
    chk("ignore_rxdata", rxData, 16'h5A5A);

    // Reset during the fifth shift-high phase.
    loop_mode = 0; sat_ld0 = 8'h11; sat_ld1 = 8'h22;
    d0 = done_cnt;
    txData = 16'hBEEF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (45) @(negedge clk);
    chk("abort_in_shift_hi", shiftClk, 1);
    #2 nReset = 1'b0;
    #1;
    chk("abort_outputs", {busy, done, shiftClk, enableShift, load, serialOut}, 0);
    chk("abort_rxdata", rxData, 0);
    repeat (3) @(negedge clk);
    nReset = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    sat_ld0 = 8'h96; sat_ld1 = 8'h69;
    txn(16'h0FF0, -1, -1, lat);
    chk("post_abort_rxdata", rxData, 16'h6996);
    chk("post_abort_sat1", sat1, 8'h0F);
    chk("post_abort_sat0", sat0, 8'hF0);
    repeat (3) @(negedge clk);

    // Back-to-back on the 1-satellite CLK_DIV=2 instance.
    start2 = 1'b1; txData2 = tx2v[0];
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      while (!done2 && lat < 200) begin
        @(negedge clk);
        lat++;
      end
      chk("b2b_interval", lat, (i == 0) ? T2 : T2 + 1);
      chk("b2b_rxdata", rxData2, tx2v[i]);
      if (i < 2) txData2 = tx2v[i + 1];
      else start2 = 1'b0;
      @(negedge clk);
      lat = 1;
    end
    repeat (50) @(negedge clk);
    chk("b2b_stopped", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
